truxton2_pcm_rom: RTL and testbench
===================================

# truxton2_pcm_rom

PCM sample-ROM responder for the Truxton II sound subsystem. It serves the ADPCM engine's byte-wide ROM handshake (PCM_CS/PCM_ADDR in, PCM_DOUT/PCM_OK out) from the shared 32-bit SDRAM port through a one-word line buffer, so that consecutive sample bytes cost one SDRAM access per four bytes. It sits between the sound block and the SDRAM arbiter in the CLK96 domain.

## Interface
- BASE, 22'h0: SDRAM word offset of the PCM region, added to every request address.
- ADDR_MASK, 20'h3FFFF: mask applied to PCM_ADDR before any use.

- CLK96  in  1  single clock; all logic rises on CLK96.
- RESET96_N  in  1  asynchronous, active-low reset.
- PCM_CS  in  1  ROM enable from the sound block.
- PCM_ADDR  in  20  byte address from the ADPCM engine.
- PCM_DOUT  out  8  byte returned for PCM_ADDR.
- PCM_OK  out  1  PCM_DOUT is valid for the current PCM_ADDR.
- INVALIDATE  in  1  one-cycle pulse; clears the line (ROM reload).
- SDR_REQ  out  1  SDRAM read request, level, held until acknowledged.
- SDR_ADDR  out  22  SDRAM 32-bit word address.
- SDR_ACK  in  1  arbiter accepted the request (one cycle).
- SDR_VALID  in  1  SDR_DATA valid (one cycle, some cycles after SDR_ACK).
- SDR_DATA  in  32  read word, little-endian bytes.

## Operation
- maddr = PCM_ADDR & ADDR_MASK. Tag = maddr[19:2]. Byte lane = maddr[1:0].
- Line state: line_tag[17:0], line_data[31:0], line_vld. Hit = line_vld and (line_tag == tag).
- FSM states:
  - IDLE: if PCM_CS and hit, register PCM_DOUT = line_data[8*lane +: 8], ok_r = 1, and latch okaddr = maddr. If PCM_CS and miss, set ok_r = 0, latch req_tag = tag, SDR_REQ = 1, SDR_ADDR = BASE + {4'b0, tag}, and go to REQ. If PCM_CS is low, set ok_r = 0 and stay in IDLE.
  - REQ: hold SDR_REQ and SDR_ADDR constant. When SDR_ACK is sampled, set SDR_REQ = 0 and go to WAIT.
  - WAIT: when SDR_VALID is sampled, set line_data = SDR_DATA, line_tag = req_tag, line_vld = 1, and go to IDLE. The hit is served on the next IDLE evaluation.
- PCM_OK = ok_r and (okaddr == maddr), combinational guard. A stale OK is never shown for a changed address.
- An address change during REQ or WAIT does not abort the fetch. The fill completes, then IDLE re-evaluates the current address, which may trigger a new miss.
- INVALIDATE:
  - Clears line_vld and ok_r at the next edge.
  - If asserted during WAIT, the fill that follows still writes data but leaves line_vld = 0.
  - SDR_REQ is never withdrawn once raised.
- Address arithmetic: BASE + tag is a 22-bit modulo sum and wraps silently.

## Timing
- Reset values: PCM_DOUT = 0, PCM_OK = 0, SDR_REQ = 0, SDR_ADDR = 0, line_vld = 0, FSM in IDLE.
- Hit latency: address stable at edge N. PCM_DOUT and PCM_OK are valid after edge N+1.
- Miss latency:
  - Miss is detected at edge N, and SDR_REQ is high after edge N.
  - SDR_ACK is sampled at edge A, and SDR_REQ is low after edge A.
  - SDR_VALID is sampled at edge V, and the line is filled after edge V.
  - PCM_OK is high after edge V+1.
  - Minimum case A = N+1, V = A+1 gives OK 4 cycles after the address.
- SDR_ACK and SDR_VALID arriving in the same cycle in REQ: ACK is taken, and VALID is ignored (protocol violation, not supported).
- At most one outstanding SDRAM request.
- Reset mid-fetch: everything returns to reset values asynchronously, and any later SDR_VALID is ignored in IDLE.

## Test plan
- Reset, then PCM_CS=1, PCM_ADDR=0x00005, with SDRAM returning 0x44332211 (ACK 1 cycle after REQ, VALID 3 cycles after ACK):
  - SDR_ADDR = 0x000001, exactly one request.
  - PCM_DOUT = 0x22, PCM_OK high 6 cycles after the address.
- Sequential bytes: addresses 0x00004–0x00007 after the fill return 0x11, 0x22, 0x33, 0x44, each with OK one cycle after the address and no new SDR_REQ. Address 0x00008 triggers SDR_ADDR = 0x000002.
- Address change mid-fetch: miss on 0x00010, switch to 0x00020 while in WAIT.
  - The fill completes for word 0x4.
  - PCM_OK stays low throughout.
  - A second request is issued for SDR_ADDR = 0x000008, then OK returns with the 0x00020 byte.
- Mask and BASE: BASE = 22'h100000, PCM_ADDR = 0xC0003 gives maddr 0x00003 and SDR_ADDR = 0x100000. BASE = 22'h3FFFFF, PCM_ADDR = 0x00004 gives SDR_ADDR = 0x000000 (wrap).
- INVALIDATE after a fill of word 1, then re-read 0x00005 gives a new SDR_REQ. INVALIDATE during WAIT leaves line_vld = 0 after the fill, so one extra request is issued.
- Stall and reset: hold SDR_ACK low for 50 cycles, and SDR_REQ and SDR_ADDR stay stable. Assert RESET96_N low mid-REQ: SDR_REQ and PCM_OK go to 0 immediately, and a late SDR_VALID after release causes no fill.

Source files
------------

// File: rtl/truxton2_pcm_rom_if.sv
// Handshake bundle for the PCM sample-ROM responder: the byte-wide ROM port
// facing the ADPCM engine and the 32-bit read port facing the SDRAM arbiter.
interface truxton2_pcm_rom_if;
  logic        PCM_CS;
  logic [19:0] PCM_ADDR;
  logic [7:0]  PCM_DOUT;
  logic        PCM_OK;
  logic        INVALIDATE;
  logic        SDR_REQ;
  logic [21:0] SDR_ADDR;
  logic        SDR_ACK;
  logic        SDR_VALID;
  logic [31:0] SDR_DATA;

  // Responder side (the ROM block itself)
  modport slave (
    input  PCM_CS, PCM_ADDR, INVALIDATE, SDR_ACK, SDR_VALID, SDR_DATA,
    output PCM_DOUT, PCM_OK, SDR_REQ, SDR_ADDR
  );

  // Requester side (sound block plus SDRAM arbiter)
  modport master (
    output PCM_CS, PCM_ADDR, INVALIDATE, SDR_ACK, SDR_VALID, SDR_DATA,
    input  PCM_DOUT, PCM_OK, SDR_REQ, SDR_ADDR
  );
endinterface

// File: rtl/truxton2_pcm_rom.sv
// PCM sample-ROM responder: serves byte reads from a one-word line buffer,
// refilling it from the shared 32-bit SDRAM port on a miss.
module truxton2_pcm_rom #(
  parameter logic [21:0] BASE      = 22'h0,
  parameter logic [19:0] ADDR_MASK = 20'h3FFFF
) (
  input  logic              CLK96,
  input  logic              RESET96_N,
  truxton2_pcm_rom_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [7:0]  dout_q, dout_d;
  logic        ok_q, ok_d;
  logic [19:0] okaddr_q, okaddr_d;
  logic [17:0] req_tag_q, req_tag_d;
  logic        sdr_req_q, sdr_req_d;
  logic [21:0] sdr_addr_q, sdr_addr_d;
  logic [17:0] line_tag_q, line_tag_d;
  logic [31:0] line_data_q, line_data_d;
  logic        line_vld_q, line_vld_d;
  // Set when the line is invalidated while a fetch is in flight, so the
  // returning word is stored but never marked valid.
  logic        inval_q, inval_d;

  logic [19:0] maddr;
  logic [17:0] tag;
  logic [1:0]  lane;
  logic        hit;

  assign maddr = bus_io.PCM_ADDR & ADDR_MASK;
  assign tag   = maddr[19:2];
  assign lane  = maddr[1:0];
  assign hit   = line_vld_q && (line_tag_q == tag);

  // OK is guarded against the live address so a stale byte never shows as valid
  assign bus_io.PCM_OK   = ok_q && (okaddr_q == maddr);
  assign bus_io.PCM_DOUT = dout_q;
  assign bus_io.SDR_REQ  = sdr_req_q;
  assign bus_io.SDR_ADDR = sdr_addr_q;

  // Next-state logic: line lookup, SDRAM fetch sequencing and invalidation
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    ok_d        = ok_q;
    okaddr_d    = okaddr_q;
    req_tag_d   = req_tag_q;
    sdr_req_d   = sdr_req_q;
    sdr_addr_d  = sdr_addr_q;
    line_tag_d  = line_tag_q;
    line_data_d = line_data_q;
    line_vld_d  = line_vld_q;
    inval_d     = inval_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.INVALIDATE) begin
          // Invalidation wins over a lookup in the same cycle
          line_vld_d = 1'b0;
          ok_d       = 1'b0;
        end else if (bus_io.PCM_CS && hit) begin
          dout_d   = line_data_q[{lane, 3'b000} +: 8];
          ok_d     = 1'b1;
          okaddr_d = maddr;
        end else if (bus_io.PCM_CS) begin
          ok_d       = 1'b0;
          req_tag_d  = tag;
          sdr_req_d  = 1'b1;
          sdr_addr_d = BASE + {4'b0000, tag};  // modulo 2^22, wraps silently
          inval_d    = 1'b0;
          state_d    = StReq;
        end else begin
          ok_d = 1'b0;
        end
      end

      StReq: begin
        if (bus_io.INVALIDATE) begin
          line_vld_d = 1'b0;
          ok_d       = 1'b0;
          inval_d    = 1'b1;
        end
        // A VALID coincident with ACK is a protocol violation and is ignored
        if (bus_io.SDR_ACK) begin
          sdr_req_d = 1'b0;
          state_d   = StWait;
        end
      end

      StWait: begin
        if (bus_io.INVALIDATE) begin
          line_vld_d = 1'b0;
          ok_d       = 1'b0;
          inval_d    = 1'b1;
        end
        if (bus_io.SDR_VALID) begin
          line_data_d = bus_io.SDR_DATA;
          line_tag_d  = req_tag_q;
          line_vld_d  = !(inval_q || bus_io.INVALIDATE);
          inval_d     = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers, all cleared asynchronously by reset
  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q     <= StIdle;
      dout_q      <= 8'h00;
      ok_q        <= 1'b0;
      okaddr_q    <= 20'h0;
      req_tag_q   <= 18'h0;
      sdr_req_q   <= 1'b0;
      sdr_addr_q  <= 22'h0;
      line_tag_q  <= 18'h0;
      line_data_q <= 32'h0;
      line_vld_q  <= 1'b0;
      inval_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      ok_q        <= ok_d;
      okaddr_q    <= okaddr_d;
      req_tag_q   <= req_tag_d;
      sdr_req_q   <= sdr_req_d;
      sdr_addr_q  <= sdr_addr_d;
      line_tag_q  <= line_tag_d;
      line_data_q <= line_data_d;
      line_vld_q  <= line_vld_d;
      inval_q     <= inval_d;
    end
  end

endmodule

// File: tb/tb_truxton2_pcm_rom.sv
// Bench for truxton2_pcm_rom: three instances (BASE 0, 0x100000, 0x3FFFFF)
// share one stimulus stream; a scoreboard checks every SDRAM request address
// and every PCM byte with its latency, measured in clock edges from the edge
// after the address was driven.
module tb_truxton2_pcm_rom;

  logic CLK96;
  logic RESET96_N;

  truxton2_pcm_rom_if b0 ();
  truxton2_pcm_rom_if b1 ();
  truxton2_pcm_rom_if b2 ();

  truxton2_pcm_rom #(.BASE(22'h000000), .ADDR_MASK(20'h3FFFF)) dut0 (
    .CLK96(CLK96), .RESET96_N(RESET96_N), .bus_io(b0)
  );
  truxton2_pcm_rom #(.BASE(22'h100000), .ADDR_MASK(20'h3FFFF)) dut1 (
    .CLK96(CLK96), .RESET96_N(RESET96_N), .bus_io(b1)
  );
  truxton2_pcm_rom #(.BASE(22'h3FFFFF), .ADDR_MASK(20'h3FFFF)) dut2 (
    .CLK96(CLK96), .RESET96_N(RESET96_N), .bus_io(b2)
  );

  // Instances 1 and 2 see exactly the inputs of instance 0
  assign b1.PCM_CS = b0.PCM_CS;         assign b2.PCM_CS = b0.PCM_CS;
  assign b1.PCM_ADDR = b0.PCM_ADDR;     assign b2.PCM_ADDR = b0.PCM_ADDR;
  assign b1.INVALIDATE = b0.INVALIDATE; assign b2.INVALIDATE = b0.INVALIDATE;
  assign b1.SDR_ACK = b0.SDR_ACK;       assign b2.SDR_ACK = b0.SDR_ACK;
  assign b1.SDR_VALID = b0.SDR_VALID;   assign b2.SDR_VALID = b0.SDR_VALID;
  assign b1.SDR_DATA = b0.SDR_DATA;     assign b2.SDR_DATA = b0.SDR_DATA;

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  int cyc = 0;
  always @(posedge CLK96) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] d;
    int         t;
    int         lat;  // -1: latency not checked
  } exp_t;
  typedef struct {
    logic [21:0] a0;
    logic [21:0] a1;
    logic [21:0] a2;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  int ack_gap = 0;  // extra cycles before ACK (0: ACK sampled one edge after REQ)
  int vld_gap = 2;  // extra cycles between ACK edge and VALID edge minus one
  bit late_go = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK96);
      #1;
    end
  endtask

  task automatic exp_req(input logic [21:0] a0, input logic [21:0] a1, input logic [21:0] a2);
    req_t r;
    r.a0 = a0; r.a1 = a1; r.a2 = a2;
    req_q.push_back(r);
  endtask

  task automatic issue(input logic [19:0] a, input bit push, input logic [7:0] d, input int lat);
    exp_t e;
    b0.PCM_ADDR = a;
    b0.PCM_CS   = 1'b1;
    if (push) begin
      e.d = d; e.t = cyc; e.lat = lat;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    case (a)
      22'h0:   return 32'h0D0C0B0A;
      22'h1:   return 32'h44332211;
      22'h2:   return 32'h88776655;
      22'h4:   return 32'hA3A2A1A0;
      22'h8:   return 32'hB3B2B1B0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // SDRAM arbiter model, following instance 0's request
  initial begin
    bit late_done;
    int n;
    bit abort;
    logic [21:0] a;
    late_done = 1'b0;
    b0.SDR_ACK = 1'b0; b0.SDR_VALID = 1'b0; b0.SDR_DATA = 32'h0;
    forever begin
      @(posedge CLK96);
      #1;
      if (late_go && !late_done) begin
        late_done = 1'b1;
        b0.SDR_VALID = 1'b1; b0.SDR_DATA = 32'h5A5A5A5A;
        step(1);
        b0.SDR_VALID = 1'b0;
      end else if (RESET96_N && b0.SDR_REQ) begin
        a = b0.SDR_ADDR;
        n = 0;
        abort = 1'b0;
        while (n < ack_gap && !abort) begin
          step(1);
          n++;
          if (!RESET96_N) abort = 1'b1;
        end
        if (!abort) begin
          b0.SDR_ACK = 1'b1;
          step(1);
          b0.SDR_ACK = 1'b0;
          repeat (vld_gap) step(1);
          b0.SDR_VALID = 1'b1; b0.SDR_DATA = mem_word(a);
          step(1);
          b0.SDR_VALID = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations on each new request and each new OK
  initial begin
    logic req_prev, ok_prev;
    logic [21:0] addr_prev;
    req_t r;
    exp_t e;
    req_prev = 1'b0; ok_prev = 1'b0; addr_prev = 22'h0;
    forever begin
      @(negedge CLK96);
      if (b0.SDR_REQ === 1'b1 && !req_prev) begin
        n_tests++;
        if (req_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_req: got request addr 0x%0h, expected none", b0.SDR_ADDR);
        end else begin
          n_tests--;
          r = req_q.pop_front();
          check("sdr_addr_base0", {10'h0, b0.SDR_ADDR}, {10'h0, r.a0});
          check("sdr_addr_base100000", {10'h0, b1.SDR_ADDR}, {10'h0, r.a1});
          check("sdr_addr_base3fffff", {10'h0, b2.SDR_ADDR}, {10'h0, r.a2});
        end
      end else if (b0.SDR_REQ === 1'b1 && req_prev) begin
        check("sdr_addr_stable", {10'h0, b0.SDR_ADDR}, {10'h0, addr_prev});
      end
      if (b0.PCM_OK === 1'b1 && !ok_prev) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ok: got OK with byte 0x%0h at addr 0x%0h, expected none",
                   b0.PCM_DOUT, b0.PCM_ADDR);
        end else begin
          n_tests--;
          e = exp_q.pop_front();
          check("pcm_dout", {24'h0, b0.PCM_DOUT}, {24'h0, e.d});
          if (e.lat >= 0) check("pcm_ok_latency", cyc - e.t, e.lat);
        end
      end
      req_prev  = (b0.SDR_REQ === 1'b1);
      ok_prev   = (b0.PCM_OK === 1'b1);
      addr_prev = b0.SDR_ADDR;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET96_N = 1'b0;
    b0.PCM_CS = 1'b0; b0.PCM_ADDR = 20'h0; b0.INVALIDATE = 1'b0;
    step(3);
    check("reset_dout", {24'h0, b0.PCM_DOUT}, 32'h0);
    check("reset_ok", {31'h0, b0.PCM_OK}, 32'h0);
    check("reset_req", {31'h0, b0.SDR_REQ}, 32'h0);
    check("reset_sdr_addr", {10'h0, b0.SDR_ADDR}, 32'h0);
    RESET96_N = 1'b1;
    step(2);

    // First miss: ACK one edge after REQ, VALID three edges after ACK
    exp_req(22'h000001, 22'h100001, 22'h000000);
    issue(20'h00005, 1'b1, 8'h22, 6);
    step(12);

    // Sequential bytes in the same word: hits, one edge each
    issue(20'h00004, 1'b1, 8'h11, 1); step(2);
    issue(20'h00005, 1'b1, 8'h22, 1); step(2);
    issue(20'h00006, 1'b1, 8'h33, 1); step(2);
    issue(20'h00007, 1'b1, 8'h44, 1); step(2);
    exp_req(22'h000002, 22'h100002, 22'h000001);
    issue(20'h00008, 1'b1, 8'h55, 6);
    step(12);

    // Address change while waiting for data: fill word 4, then fetch word 8
    exp_req(22'h000004, 22'h100004, 22'h000003);
    issue(20'h00010, 1'b0, 8'h00, -1);
    step(2);
    exp_req(22'h000008, 22'h100008, 22'h000007);
    issue(20'h00020, 1'b1, 8'hB0, -1);
    step(16);

    // Mask and BASE wrap
    exp_req(22'h000000, 22'h100000, 22'h3FFFFF);
    issue(20'hC0003, 1'b1, 8'h0D, 6);
    step(12);
    exp_req(22'h000001, 22'h100001, 22'h000000);
    issue(20'h00004, 1'b1, 8'h11, 6);
    step(12);

    // Invalidate a filled line: the re-read of the same word fetches again
    exp_req(22'h000001, 22'h100001, 22'h000000);
    issue(20'h00005, 1'b1, 8'h22, 7);
    b0.INVALIDATE = 1'b1;
    step(1);
    b0.INVALIDATE = 1'b0;
    step(12);

    // Invalidate while waiting: fill is not marked valid, so one extra fetch
    exp_req(22'h000002, 22'h100002, 22'h000001);
    exp_req(22'h000002, 22'h100002, 22'h000001);
    issue(20'h00008, 1'b1, 8'h55, 11);
    step(2);
    b0.INVALIDATE = 1'b1;
    step(1);
    b0.INVALIDATE = 1'b0;
    step(16);

    // Stalled arbiter, then reset in the middle of the request
    ack_gap = 100;
    exp_req(22'h00000C, 22'h10000C, 22'h00000B);
    issue(20'h00030, 1'b0, 8'h00, -1);
    step(50);
    RESET96_N = 1'b0;
    b0.PCM_CS = 1'b0;
    #1;
    check("midreq_reset_req", {31'h0, b0.SDR_REQ}, 32'h0);
    check("midreq_reset_ok", {31'h0, b0.PCM_OK}, 32'h0);
    check("midreq_reset_addr", {10'h0, b0.SDR_ADDR}, 32'h0);
    step(2);
    RESET96_N = 1'b1;
    ack_gap = 0;
    step(1);
    late_go = 1'b1;
    step(4);
    // A late VALID in IDLE must not fill the line: word 0 still misses
    exp_req(22'h000000, 22'h100000, 22'h3FFFFF);
    issue(20'h00000, 1'b1, 8'h0A, 6);
    step(12);

    check("req_queue_drained", req_q.size(), 32'h0);
    check("ok_queue_drained", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
